// File: rtl/driver_monitor_readout.sv
// driver_monitor_readout
// Snapshots the driver monitor's gap histogram and current gap count, then
// streams them as one fixed-length frame over a valid/ready port.
// A frame starts on a rising edge of end_program or on a snap_req pulse.
// Triggers that arrive while a frame is in flight are dropped and counted.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   end_program     program-end level; its rising edge triggers a frame
//   snap_req        single-cycle software snapshot request
//   mon_cnts        flattened histogram, bin i at [i*BIN_W +: BIN_W]
//   addr_cycle_cnt  live gap counter from the monitor
//   out_data/out_valid/out_ready/out_last  frame word stream
//   busy            FSM is not in IDLE
//   seq             sequence number of the most recently started frame
//   missed_cnt      triggers dropped while busy, saturating at 8'hFF
//
// state | meaning
// IDLE  | waiting for a trigger
// HDR   | presenting {D1A6, NUM_BINS, seq}
// BINS  | presenting bin pair k, for k = 0..NUM_BINS/2-1
// GAP   | presenting the latched gap count
// SUM   | presenting the sum of all latched bins
// FLAGS | presenting the saturated-bin mask, out_last = 1
module driver_monitor_readout #(
  parameter int NUM_BINS = 16,
  parameter int BIN_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      end_program,
  input  logic                      snap_req,
  input  logic [NUM_BINS*BIN_W-1:0] mon_cnts,
  input  logic [31:0]               addr_cycle_cnt,
  output logic [31:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic [7:0]                seq,
  output logic [7:0]                missed_cnt
);

  localparam int PAIRS = NUM_BINS / 2;
  localparam int K_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int SUM_W = 20;

  typedef enum logic [2:0] {IDLE, HDR, BINS, GAP, SUM, FLAGS} state_t;

  state_t           state;
  logic [BIN_W-1:0] shadow_bin [NUM_BINS];
  logic [31:0]      shadow_gap;
  logic [SUM_W-1:0] sum_acc;
  logic [K_W-1:0]   k;
  logic [K_W-1:0]   k_nxt;
  logic             end_prog_q;
  logic             edge_armed;
  logic             trig;
  logic             hs;
  logic [7:0]       seq_inc;
  logic [31:0]      pair_word [PAIRS];
  logic [SUM_W-1:0] pair_sum  [PAIRS];
  logic [31:0]      flags_word;

  // end_prog_q reads 0 straight out of reset, so a level already high at
  // release would look like an edge. edge_armed blocks the end_program
  // trigger until the level has been seen low at least once.
  assign trig    = (end_program & ~end_prog_q & edge_armed) | snap_req;
  assign hs      = out_valid & out_ready;
  assign busy    = (state != IDLE);
  assign seq_inc = seq + 8'd1;
  assign k_nxt   = k + K_W'(1);

  always_comb begin
    for (int i = 0; i < PAIRS; i++) begin
      pair_word[i] = 32'({shadow_bin[2*i+1], shadow_bin[2*i]});
      pair_sum[i]  = SUM_W'(shadow_bin[2*i]) + SUM_W'(shadow_bin[2*i+1]);
    end
    flags_word = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      flags_word[i] = (shadow_bin[i] == '1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < NUM_BINS; i++) shadow_bin[i] <= '0;
      shadow_gap <= '0;
      sum_acc    <= '0;
      k          <= '0;
      end_prog_q <= 1'b0;
      edge_armed <= 1'b0;
      seq        <= '0;
      missed_cnt <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      end_prog_q <= end_program;
      if (!end_program) edge_armed <= 1'b1;

      if (state == IDLE) begin
        if (trig) begin
          for (int i = 0; i < NUM_BINS; i++) begin
            shadow_bin[i] <= mon_cnts[i*BIN_W +: BIN_W];
          end
          shadow_gap <= addr_cycle_cnt;
          seq        <= seq_inc;
          sum_acc    <= '0;
          k          <= '0;
          out_data   <= {16'hD1A6, 8'(NUM_BINS), seq_inc};
          out_valid  <= 1'b1;
          out_last   <= 1'b0;
          state      <= HDR;
        end
      end else begin
        // A trigger during a frame is never queued, only counted.
        if (trig && missed_cnt != 8'hFF) missed_cnt <= missed_cnt + 8'd1;

        if (hs) begin
          case (state)
            HDR: begin
              out_data <= pair_word[0];
              state    <= BINS;
            end
            BINS: begin
              sum_acc <= sum_acc + pair_sum[k];
              if (k == K_W'(PAIRS - 1)) begin
                out_data <= shadow_gap;
                state    <= GAP;
              end else begin
                k        <= k_nxt;
                out_data <= pair_word[k_nxt];
              end
            end
            GAP: begin
              out_data <= {{(32-SUM_W){1'b0}}, sum_acc};
              state    <= SUM;
            end
            SUM: begin
              out_data <= flags_word;
              out_last <= 1'b1;
              state    <= FLAGS;
            end
            default: begin
              out_data  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_driver_monitor_readout.sv
module tb_driver_monitor_readout;

  logic         clk = 1'b0;
  logic         reset;
  logic         end_program;
  logic         snap_req;
  logic [255:0] mon_cnts;
  logic [31:0]  addr_cycle_cnt;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [7:0]   seq;
  logic [7:0]   missed_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_w [12];
  logic [31:0] got [12];
  logic        got_last [12];
  int          first_v;
  int          last_hs;

  always #5 clk = ~clk;

  driver_monitor_readout #(.NUM_BINS(16), .BIN_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .end_program    (end_program),
    .snap_req       (snap_req),
    .mon_cnts       (mon_cnts),
    .addr_cycle_cnt (addr_cycle_cnt),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .seq            (seq),
    .missed_cnt     (missed_cnt)
  );

  // Expected frame from the current mon_cnts/addr_cycle_cnt and sequence number.
  task automatic build_exp(input logic [7:0] s);
    logic [15:0] b [16];
    logic [19:0] sum;
    logic [15:0] flags;
    sum   = '0;
    flags = '0;
    for (int i = 0; i < 16; i++) begin
      b[i]     = mon_cnts[i*16 +: 16];
      sum      = sum + 20'(b[i]);
      flags[i] = (b[i] == 16'hFFFF);
    end
    exp_w[0] = {16'hD1A6, 8'd16, s};
    for (int j = 0; j < 8; j++) exp_w[1+j] = {b[2*j+1], b[2*j]};
    exp_w[9]  = addr_cycle_cnt;
    exp_w[10] = {12'h000, sum};
    exp_w[11] = {16'h0000, flags};
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) mon_cnts[i*16 +: 16] = 16'(i*3 + 1);
  endtask

  // Called right after a trigger has been set up at a negedge; collects 12 words.
  task automatic collect(input bit stall, input bit inject, input string name);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    first_v = -1;
    last_hs = -1;
    while (n < 12 && cyc < 200) begin
      @(negedge clk);
      snap_req = 1'b0;
      if (inject && (cyc == 3 || cyc == 5 || cyc == 7)) snap_req = 1'b1;
      if (inject && cyc == 4) mon_cnts[15:0] = 16'h1234;
      if (out_valid && first_v < 0) first_v = cyc;
      out_ready = !stall || first_v < 0 || ((cyc - first_v) % 2 == 0);
      if (stall && out_valid) begin
        total++;
        if (out_data !== exp_w[n]) begin
          bad++;
          $display("FAIL %s hold word%0d cyc%0d got=%h want=%h", name, n, cyc, out_data, exp_w[n]);
        end
      end
      if (out_valid && out_ready) begin
        got[n]      = out_data;
        got_last[n] = out_last;
        last_hs     = cyc;
        n++;
      end
      cyc++;
    end
    total++;
    if (n != 12) begin
      bad++;
      $display("FAIL %s word_count got=%0d want=12", name, n);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got[i] !== exp_w[i]) begin
        bad++;
        $display("FAIL %s word%0d got=%h want=%h", name, i, got[i], exp_w[i]);
      end
      total++;
      if (got_last[i] !== (i == 11)) begin
        bad++;
        $display("FAIL %s last%0d got=%b want=%b", name, i, got_last[i], (i == 11));
      end
    end
  endtask

  task automatic check_idle(input string name, input logic [7:0] exp_seq, input logic [7:0] exp_missed);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL %s idle got busy=%b valid=%b last=%b want 0 0 0", name, busy, out_valid, out_last);
    end
    total++;
    if (seq !== exp_seq) begin
      bad++;
      $display("FAIL %s seq got=%h want=%h", name, seq, exp_seq);
    end
    total++;
    if (missed_cnt !== exp_missed) begin
      bad++;
      $display("FAIL %s missed got=%h want=%h", name, missed_cnt, exp_missed);
    end
  endtask

  task automatic frame_fast();
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    while (!(out_valid && out_last) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc >= 40) begin
      bad++;
      $display("FAIL fast_frame timeout got=%0d want<40", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_async got valid=%b data=%h want 0 0", out_valid, out_data);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", out_data);
    end
    check_idle("reset", 8'h00, 8'h00);
  endtask

  task automatic test_basic();
    set_ramp();
    addr_cycle_cnt = 32'd77;
    build_exp(8'h01);
    @(negedge clk);
    end_program = 1'b1;
    collect(1'b0, 1'b0, "basic");
    total++;
    if (got[0] !== 32'hD1A61001 || got[1] !== 32'h00040001 || got[2] !== 32'h000A0007 ||
        got[8] !== 32'h002E002B || got[9] !== 32'h0000004D || got[10] !== 32'h00000178 ||
        got[11] !== 32'h00000000) begin
      bad++;
      $display("FAIL basic_const got %h %h %h %h %h %h %h want D1A61001 00040001 000A0007 002E002B 0000004D 00000178 00000000",
               got[0], got[1], got[2], got[8], got[9], got[10], got[11]);
    end
    total++;
    if (last_hs !== 11) begin
      bad++;
      $display("FAIL basic_throughput last_hs got=%0d want=11", last_hs);
    end
    @(negedge clk);
    check_idle("basic", 8'h01, 8'h00);
    end_program = 1'b0;
  endtask

  task automatic test_stall();
    build_exp(8'h02);
    @(negedge clk);
    snap_req = 1'b1;
    collect(1'b1, 1'b0, "stall");
    total++;
    if (last_hs - first_v + 1 !== 23) begin
      bad++;
      $display("FAIL stall_cycles got=%0d want=23", last_hs - first_v + 1);
    end
    @(negedge clk);
    check_idle("stall", 8'h02, 8'h00);
  endtask

  task automatic test_missed();
    build_exp(8'h03);
    @(negedge clk);
    snap_req = 1'b1;
    collect(1'b0, 1'b1, "missed");
    @(negedge clk);
    check_idle("missed", 8'h03, 8'h03);
  endtask

  task automatic test_back_to_back();
    build_exp(8'h04);
    @(negedge clk);
    snap_req = 1'b1;
    collect(1'b0, 1'b0, "b2b_a");
    snap_req = 1'b1;            // sampled on the final handshake edge: dropped
    @(negedge clk);
    check_idle("b2b_gap", 8'h04, 8'h04);
    build_exp(8'h05);           // still high: sampled one edge later, accepted
    collect(1'b0, 1'b0, "b2b_b");
    @(negedge clk);
    check_idle("b2b", 8'h05, 8'h04);
  endtask

  task automatic test_saturate();
    mon_cnts = '1;
    build_exp(8'h06);
    @(negedge clk);
    snap_req = 1'b1;
    collect(1'b0, 1'b0, "sat_all");
    total++;
    if (got[10] !== 32'h000FFFF0 || got[11] !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL sat_all got sum=%h flags=%h want 000FFFF0 0000FFFF", got[10], got[11]);
    end
    @(negedge clk);
    mon_cnts = '0;
    mon_cnts[3*16 +: 16] = 16'hFFFF;
    build_exp(8'h07);
    snap_req = 1'b1;
    collect(1'b0, 1'b0, "sat_bin3");
    total++;
    if (got[11] !== 32'h00000008 || got[10] !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL sat_bin3 got flags=%h sum=%h want 00000008 0000FFFF", got[11], got[10]);
    end
    @(negedge clk);
    check_idle("sat", 8'h07, 8'h04);
  endtask

  task automatic test_reset_mid();
    int seen;
    set_ramp();
    build_exp(8'h08);
    out_ready = 1'b1;
    @(negedge clk);
    end_program = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== exp_w[4]) begin
      bad++;
      $display("FAIL rstmid_word4 got valid=%b data=%h want 1 %h", out_valid, out_data, exp_w[4]);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || seq !== 8'h00 || missed_cnt !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_async got valid=%b last=%b busy=%b seq=%h missed=%h want 0 0 0 00 00",
               out_valid, out_last, busy, seq, missed_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rstmid_held_high valid_cycles got=%0d want=0", seen);
    end
    end_program = 1'b0;
    @(negedge clk);
    build_exp(8'h01);
    end_program = 1'b1;
    collect(1'b0, 1'b0, "after_rst");
    @(negedge clk);
    end_program = 1'b0;
    check_idle("after_rst", 8'h01, 8'h00);
  endtask

  task automatic test_wrap();
    int cyc;
    @(negedge clk);
    out_ready = 1'b0;
    snap_req  = 1'b1;
    @(negedge clk);              // accepted: seq 2, frame stalled
    repeat (254) @(negedge clk);
    total++;
    if (missed_cnt !== 8'hFE) begin
      bad++;
      $display("FAIL wrap_missed254 got=%h want=FE", missed_cnt);
    end
    repeat (46) @(negedge clk);
    total++;
    if (missed_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL wrap_missed300 got=%h want=FF", missed_cnt);
    end
    snap_req  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid && out_last) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check_idle("wrap_drain", 8'h02, 8'hFF);
    repeat (253) frame_fast();
    total++;
    if (seq !== 8'hFF) begin
      bad++;
      $display("FAIL wrap_seq_ff got=%h want=FF", seq);
    end
    frame_fast();
    check_idle("wrap_seq", 8'h00, 8'hFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    end_program    = 1'b0;
    snap_req       = 1'b0;
    out_ready      = 1'b1;
    mon_cnts       = '0;
    addr_cycle_cnt = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_missed();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
